// File: rtl/shifter_pkg.sv
// Shared types and defaults for the display shift-register arbiter.
package shifter_pkg;

    typedef enum logic [1:0] {
        CLEAR,
        IDLE,
        SETUP,
        HIGH
    } state_e;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    localparam int DEF_CLK_DIV    = 4;
    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MR_CYCLES  = 4;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_phase_timer.sv
// Loadable down-counter; tc is high while the count sits at zero.
module shift_phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         tc
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (load) begin
            cnt <= load_val;
        end else if (!tc) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tc = (cnt == '0);

endmodule

// File: rtl/shifter_arbiter.sv
// Round-robin sharing of one serial shift-register chain between two
// byte requesters, with MSB-first serialisation and MR_N clear pulses.
module shifter_arbiter
    import shifter_pkg::*;
#(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MR_CYCLES  = DEF_MR_CYCLES
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_a_valid,
    input  logic [DATA_WIDTH-1:0] i_a_data,
    output logic                  o_a_ready,
    input  logic                  i_b_valid,
    input  logic [DATA_WIDTH-1:0] i_b_data,
    output logic                  o_b_ready,
    input  logic                  i_clear,
    output logic                  o_shifter_ds,
    output logic                  o_shifter_cp,
    output logic                  o_shifter_mr_n,
    output logic                  o_busy,
    output logic                  o_grant_b
);

    localparam int TMAX = (CLK_DIV > MR_CYCLES) ? CLK_DIV : MR_CYCLES;
    localparam int CW   = cnt_w(TMAX);
    localparam int IW   = cnt_w(DATA_WIDTH);

    localparam logic [CW-1:0] HALF_LD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CLR_LD  = CW'(MR_CYCLES - 1);
    localparam logic [IW-1:0] IDX_TOP = IW'(DATA_WIDTH - 1);

    state_e                  state, state_n;
    logic                    t_load, t_tc;
    logic [CW-1:0]           t_val;
    logic [IW-1:0]           idx, idx_dn;
    logic [DATA_WIDTH-1:0]   shreg;
    logic                    prio_b, grant_b, ds;
    logic                    sel_b, xfer, last_bit, idle;

    shift_phase_timer #(.W(CW)) u_timer (
        .clk      (i_clk),
        .load     (t_load),
        .load_val (t_val),
        .tc       (t_tc)
    );

    // B wins when it is the only requester or holds priority
    assign sel_b    = i_b_valid & (~i_a_valid | prio_b);
    assign idle     = (state == IDLE);
    assign o_a_ready = idle & ~i_clear & ~sel_b & i_a_valid;
    assign o_b_ready = idle & ~i_clear & sel_b & i_b_valid;
    assign xfer     = o_a_ready | o_b_ready;
    assign last_bit = (idx == '0);
    assign idx_dn   = idx - 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= CLEAR;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        t_load  = 1'b0;
        t_val   = HALF_LD;
        unique case (state)
            CLEAR: begin
                if (t_tc) state_n = IDLE;
            end
            IDLE: begin
                if (i_clear) begin
                    state_n = CLEAR;
                    t_load  = 1'b1;
                    t_val   = CLR_LD;
                end else if (xfer) begin
                    state_n = SETUP;
                    t_load  = 1'b1;
                end
            end
            SETUP: begin
                if (t_tc) begin
                    state_n = HIGH;
                    t_load  = 1'b1;
                end
            end
            HIGH: begin
                if (t_tc) begin
                    state_n = last_bit ? IDLE : SETUP;
                    t_load  = ~last_bit;
                end
            end
            default: state_n = CLEAR;
        endcase
        if (i_reset) begin
            t_load = 1'b1;
            t_val  = CLR_LD;
        end
    end

    // ds only moves on edges where cp is (or becomes) low
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            ds      <= 1'b0;
            shreg   <= '0;
            idx     <= '0;
            prio_b  <= GRANT_A;
            grant_b <= GRANT_A;
        end else begin
            if (state == CLEAR) ds <= 1'b0;
            if (xfer) begin
                shreg   <= sel_b ? i_b_data : i_a_data;
                idx     <= IDX_TOP;
                grant_b <= sel_b ? GRANT_B : GRANT_A;
                prio_b  <= ~sel_b;
                ds      <= sel_b ? i_b_data[DATA_WIDTH-1]
                                 : i_a_data[DATA_WIDTH-1];
            end else if (state == HIGH && t_tc && !last_bit) begin
                idx <= idx_dn;
                ds  <= shreg[idx_dn];
            end
        end
    end

    assign o_shifter_ds   = ds;
    assign o_shifter_cp   = (state == HIGH);
    assign o_shifter_mr_n = (state != CLEAR);
    assign o_busy         = ~idle;
    assign o_grant_b      = grant_b;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed bench for shifter_arbiter: default timing plus a CLK_DIV=1 copy.
module tb_shifter_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a_v = 1'b0, b_v = 1'b0, clr = 1'b0;
    logic [7:0] a_d = '0, b_d = '0;
    logic       a_rdy, b_rdy, ds0, cp0, mr0, busy0, gb0;

    logic       a1_v = 1'b0, b1_v = 1'b0, clr1 = 1'b0;
    logic [7:0] a1_d = '0, b1_d = '0;
    logic       a1_rdy, b1_rdy, ds1, cp1, mr1, busy1, gb1;

    int  n_cmp = 0;
    int  n_bad = 0;
    bit  sel = 1'b0;
    int  clr_at = -1;

    int          rises, idle_k, r1k, r2k;
    logic [15:0] bits;

    logic w_busy, w_cp, w_ds;
    assign w_busy = sel ? busy1 : busy0;
    assign w_cp   = sel ? cp1 : cp0;
    assign w_ds   = sel ? ds1 : ds0;

    always #5 clk = ~clk;

    shifter_arbiter dut0 (
        .i_clk(clk), .i_reset(rst),
        .i_a_valid(a_v), .i_a_data(a_d), .o_a_ready(a_rdy),
        .i_b_valid(b_v), .i_b_data(b_d), .o_b_ready(b_rdy),
        .i_clear(clr),
        .o_shifter_ds(ds0), .o_shifter_cp(cp0),
        .o_shifter_mr_n(mr0), .o_busy(busy0), .o_grant_b(gb0)
    );

    shifter_arbiter #(.CLK_DIV(1)) dut1 (
        .i_clk(clk), .i_reset(rst),
        .i_a_valid(a1_v), .i_a_data(a1_d), .o_a_ready(a1_rdy),
        .i_b_valid(b1_v), .i_b_data(b1_d), .o_b_ready(b1_rdy),
        .i_clear(clr1),
        .o_shifter_ds(ds1), .o_shifter_cp(cp1),
        .o_shifter_mr_n(mr1), .o_busy(busy1), .o_grant_b(gb1)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at the sample just after the accept edge (k=1).
    task automatic watch();
        logic pcp;
        pcp    = 1'b0;
        rises  = 0;
        bits   = '0;
        idle_k = -1;
        r1k    = -1;
        r2k    = -1;
        for (int k = 1; k < 400; k++) begin
            if (k > 1) step();
            if (!w_busy) begin
                idle_k = k;
                break;
            end
            if (w_cp && !pcp) begin
                if (rises == 0) r1k = k;
                if (rises == 1) r2k = k;
                bits = {bits[14:0], w_ds};
                rises++;
                if (rises == clr_at) clr = 1'b1;
            end
            pcp = w_cp;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // reset and power-on clear
        repeat (3) begin
            step();
            chk("rst_mr_n", mr0, 0);
            chk("rst_cp", cp0, 0);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("clr_mr_n", mr0, 0);
            step();
        end
        chk("idle_mr_n", mr0, 1);
        chk("idle_busy", busy0, 0);
        chk("idle_cp", cp0, 0);
        chk("idle_ds", ds0, 0);

        // single A frame 0xA5
        a_v = 1'b1;
        a_d = 8'hA5;
        #1;
        chk("a5_a_ready", a_rdy, 1);
        chk("a5_b_ready", b_rdy, 0);
        step();
        chk("a5_ready_busy", a_rdy, 0);
        chk("a5_busy", busy0, 1);
        a_v = 1'b0;
        sel = 1'b0;
        watch();
        chk("a5_rises", rises, 8);
        chk("a5_bits", bits[7:0], 8'hA5);
        chk("a5_first_rise", r1k, 5);
        chk("a5_idle_at", idle_k, 65);
        chk("a5_grant_b", gb0, 0);

        // fresh reset, then both requesters contend
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        for (int i = 0; i < 20 && busy0; i++) step();
        chk("rr_idle", busy0, 0);
        a_v = 1'b1;
        b_v = 1'b1;
        a_d = 8'h0F;
        b_d = 8'hF0;
        #1;
        chk("rr1_a_ready", a_rdy, 1);
        chk("rr1_b_ready", b_rdy, 0);
        step();
        chk("rr1_grant_b", gb0, 0);
        watch();
        chk("rr1_bits", bits[7:0], 8'h0F);
        chk("rr1_idle_at", idle_k, 65);
        chk("rr2_b_ready", b_rdy, 1);
        chk("rr2_a_ready", a_rdy, 0);
        step();
        chk("rr2_grant_b", gb0, 1);
        watch();
        chk("rr2_bits", bits[7:0], 8'hF0);
        chk("rr2_idle_at", idle_k, 65);
        chk("rr3_a_ready", a_rdy, 1);
        chk("rr3_b_ready", b_rdy, 0);
        step();
        chk("rr3_grant_b", gb0, 0);
        a_v = 1'b0;
        b_v = 1'b0;
        watch();
        chk("rr3_bits", bits[7:0], 8'h0F);

        // clear raised mid-frame is deferred to IDLE
        a_v = 1'b1;
        a_d = 8'h3C;
        #1;
        chk("cl_a_ready", a_rdy, 1);
        step();
        a_v = 1'b0;
        clr_at = 5;
        watch();
        clr_at = -1;
        chk("cl_rises", rises, 8);
        chk("cl_bits", bits[7:0], 8'h3C);
        chk("cl_idle_at", idle_k, 65);
        a_v = 1'b1;
        a_d = 8'h11;
        #1;
        chk("cl_wins_ready", a_rdy, 0);
        chk("cl_pre_mr_n", mr0, 1);
        step();
        clr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("cl_mr_n_low", mr0, 0);
            chk("cl_no_ready", a_rdy, 0);
            step();
        end
        chk("cl_mr_n_back", mr0, 1);
        chk("cl_after_ready", a_rdy, 1);
        a_v = 1'b0;

        // reset during bit 5 of an A frame
        a_v = 1'b1;
        a_d = 8'hFF;
        #1;
        chk("mr_a_ready", a_rdy, 1);
        step();
        a_v = 1'b0;
        repeat (21) step();
        chk("mr_bit5_cp", cp0, 1);
        chk("mr_bit5_ds", ds0, 1);
        rst = 1'b1;
        step();
        chk("mr_cp", cp0, 0);
        chk("mr_ds", ds0, 0);
        chk("mr_mr_n", mr0, 0);
        chk("mr_grant_b", gb0, 0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("mr_clr_mr_n", mr0, 0);
            chk("mr_clr_cp", cp0, 0);
            step();
        end
        chk("mr_idle_busy", busy0, 0);
        chk("mr_idle_ds", ds0, 0);
        a_v = 1'b1;
        b_v = 1'b1;
        #1;
        chk("mr_prio_a", a_rdy, 1);
        chk("mr_prio_b", b_rdy, 0);
        a_v = 1'b0;
        b_v = 1'b0;

        // CLK_DIV=1 instance, B frame 0x81
        sel = 1'b1;
        b1_v = 1'b1;
        b1_d = 8'h81;
        #1;
        chk("d1_b_ready", b1_rdy, 1);
        chk("d1_a_ready", a1_rdy, 0);
        step();
        b1_v = 1'b0;
        watch();
        chk("d1_rises", rises, 8);
        chk("d1_bits", bits[7:0], 8'h81);
        chk("d1_first_rise", r1k, 2);
        chk("d1_cp_period", r2k - r1k, 2);
        chk("d1_idle_at", idle_k, 17);
        chk("d1_grant_b", gb1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/shifter_arbiter.md
Name: shifter_arbiter

Overview:
Shares one serial-in shift-register chain (DS/CP/MR_N, 74HC164/595-style, as driven for the numeric display) between two byte-wide requesters. Round-robin arbitration over valid/ready handshakes, MSB-first serialisation with a programmable CP rate, and master-reset pulses both after reset and on request. Sits between the display counter logic and the board pins in the top level.

Parameters:
- CLK_DIV, 4, i_clk cycles per CP half-period; legal range ≥1.
- DATA_WIDTH, 8, bits per frame.
- MR_CYCLES, 4, i_clk cycles MR_N is held low per clear; legal range ≥1.

Ports:
- i_clk  in  1  system clock (25 MHz)
- i_reset  in  1  synchronous, active-high reset
- i_a_valid  in  1  requester A has a frame
- i_a_data  in  DATA_WIDTH  requester A frame
- o_a_ready  out  1  A frame accepted this cycle
- i_b_valid  in  1  requester B has a frame
- i_b_data  in  DATA_WIDTH  requester B frame
- o_b_ready  out  1  B frame accepted this cycle
- i_clear  in  1  level request to pulse MR_N
- o_shifter_ds  out  1  serial data
- o_shifter_cp  out  1  shift clock
- o_shifter_mr_n  out  1  shifter master reset, active low
- o_busy  out  1  state ≠ IDLE
- o_grant_b  out  1  owner of the last/current frame (0 = A, 1 = B)

Behaviour:
- One clock; reset is synchronous and active-high on i_reset. All state is updated on the rising edge of i_clk.
- States: CLEAR, IDLE, SETUP, HIGH.
- Reset (also mid-frame): next state CLEAR, clear counter 0, ds=0, cp=0, mr_n=0, priority=A, o_grant_b=0. The frame in progress is discarded.
- CLEAR: mr_n=0, cp=0, ds=0 for exactly MR_CYCLES cycles, then IDLE with mr_n=1.
- IDLE arbitration, evaluated every cycle:
  - i_clear has top priority → CLEAR. No ready is issued that cycle.
  - Otherwise, if only one requester is valid, grant it.
  - If both are valid, grant the priority holder.
  - ready is asserted combinationally for the granted requester only: o_x_ready = IDLE & ~i_clear & grant_x & i_x_valid.
- On a transfer: latch data into the shift register, set bit index to DATA_WIDTH-1, set o_grant_b, flip priority to the other requester, and go to SETUP.
- SETUP: ds=data[idx], cp=0, held CLK_DIV cycles → HIGH.
- HIGH: ds unchanged, cp=1, held CLK_DIV cycles.
  - If idx=0 → IDLE (cp=0, ds holds its last value).
  - Otherwise idx−1 → SETUP.
- Frame timing: accept at cycle T → busy from T+1. The first CP rising edge is at T+1+CLK_DIV. IDLE is re-entered at T+1+2·CLK_DIV·DATA_WIDTH (T+65 for the defaults), and the next accept can occur that same cycle.
- ds changes only while cp=0. It is stable for CLK_DIV cycles before each rising edge and for CLK_DIV cycles after it.
- i_valid/i_data seen while busy are ignored (no ready). Requesters must hold valid/data until ready.
- i_clear while busy is held off until IDLE (level-sensitive) and never truncates a frame.
- CLK_DIV=1: each bit takes 2 cycles; the phase counter wraps 0→0.
- Counters use $clog2 widths with a minimum of 1 bit; no overflow is possible.

Decomposition:
- Shared package shifter_pkg:
  - state enum (CLEAR, IDLE, SETUP, HIGH)
  - GRANT_A / GRANT_B constants
  - default CLK_DIV / MR_CYCLES / DATA_WIDTH
- One sub-module, shift_phase_timer: loadable down-counter with a terminal-count pulse, reused for the CLEAR duration and the CP half-periods.

Test Plan:
1. Reset for 3 cycles, then release → mr_n=0 for exactly 4 cycles, then mr_n=1, busy=0, cp=0, ds=0.
2. A valid, data 0xA5 → a_ready for one cycle; 8 CP rising edges; ds sampled at each rising edge reads 1,0,1,0,0,1,0,1; busy drops 65 cycles after the accept.
3. A and B valid together from IDLE with data 0x0F / 0xF0 → A is served first, then B immediately on IDLE return; o_grant_b goes 0 then 1; with both kept valid, grants alternate A, B, A.
4. i_clear raised during bit 3 of a frame → the frame completes all 8 edges, then mr_n=0 for 4 cycles; with i_clear and A valid in IDLE, clear wins and a_ready stays 0.
5. i_reset asserted mid-frame (bit 5) → next cycle cp=0, ds=0, mr_n=0, priority=A; the frame is never resumed.
6. CLK_DIV=1, B data 0x81 → CP period of 2 cycles, 16-cycle frame, ds sequence 1,0,0,0,0,0,0,1.
